// File: rtl/serial_frame_ctrl_pkg.sv
// Shared encodings for the serial frame sequencer: FSM states, counter widths
// and the bundle of registered strobes the controller drives.
package serial_pkg;

  localparam int FRAME_CNT_W = 16;
  localparam int GAP_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  typedef struct packed {
    logic in_ready;
    logic ser_en;
    logic frame_start;
    logic busy;
    logic done;
  } strb_t;

  localparam strb_t STRB_RST = '{in_ready: 1'b1, default: 1'b0};

endpackage

// File: rtl/serial_frame_ctrl_shift_reg_ple.sv
// Parallel-load shift chain with enable and selectable shift direction.
// The head bit is a flop output; zeros fill in behind the data.
module shift_reg_ple #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_head
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shifted = {r_q[WIDTH-2:0], 1'b0};
      assign o_head    = r_q[WIDTH-1];
    end else begin : g_lsb
      assign w_shifted = {1'b0, r_q[WIDTH-1:1]};
      assign o_head    = r_q[0];
    end
  endgenerate

  // Clear beats load so an abort always leaves the line quiet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_q <= '0;
    else if (i_clr)  r_q <= '0;
    else if (i_load) r_q <= i_data;
    else if (i_en)   r_q <= w_shifted;
  end

endmodule

// File: rtl/serial_frame_ctrl.sv
// Frame sequencer: accepts a parallel word, shifts it out one bit per clock,
// then inserts an idle gap. All strobes are registered.
module serial_frame_ctrl
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_in_valid,
  input  logic [WIDTH-1:0]       i_in_data,
  output logic                   o_in_ready,
  input  logic                   i_abort,
  output logic                   o_ser_out,
  output logic                   o_ser_en,
  output logic                   o_frame_start,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [FRAME_CNT_W-1:0] o_frames_sent
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] LAST_GAP = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;

  state_e                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [GAP_CNT_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
  logic [FRAME_CNT_W-1:0] r_frames, w_frames_nxt;
  strb_t                  r_strb, w_strb_nxt;
  logic                   w_load, w_shift, w_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_frames  <= '0;
      r_strb    <= STRB_RST;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_frames  <= w_frames_nxt;
      r_strb    <= w_strb_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_frames_nxt  = r_frames;
    w_strb_nxt    = '0;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    w_clr         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // abort in IDLE suppresses acceptance
        if (r_strb.in_ready && i_in_valid && !i_abort) begin
          w_load                 = 1'b1;
          w_state_nxt            = ST_SHIFT;
          w_bit_cnt_nxt          = '0;
          w_strb_nxt.ser_en      = 1'b1;
          w_strb_nxt.frame_start = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (i_abort) begin
          w_clr         = 1'b1;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_shift = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_cnt_nxt   = '0;
            w_gap_cnt_nxt   = '0;
            w_frames_nxt    = r_frames + 1'b1;
            w_strb_nxt.done = 1'b1;
            w_state_nxt     = (GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            w_bit_cnt_nxt     = r_bit_cnt + 1'b1;
            w_strb_nxt.ser_en = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (i_abort || r_gap_cnt == LAST_GAP) begin
          w_gap_cnt_nxt = '0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_strb_nxt.busy     = (w_state_nxt != ST_IDLE);
    w_strb_nxt.in_ready = (w_state_nxt == ST_IDLE);
  end

  shift_reg_ple #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_chain (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .i_load(w_load),
    .i_en  (w_shift),
    .i_data(i_in_data),
    .o_head(o_ser_out)
  );

  assign o_in_ready    = r_strb.in_ready;
  assign o_ser_en      = r_strb.ser_en;
  assign o_frame_start = r_strb.frame_start;
  assign o_busy        = r_strb.busy;
  assign o_done        = r_strb.done;
  assign o_frames_sent = r_frames;

endmodule
